// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Pipeline MEM stage: load-response capture, byte/half extraction
//            and sign extension, flush tracking of stale memory responses.
// Revision : 1.0
// ============================================================================
module mem_stage (
    input  logic           clk,
    input  logic           resetn,
    output logic           ms_allowin,
    input  logic           es_to_ms_valid,
    input  logic [109:0]   es_to_ms_bus,
    input  logic           ws_allowin,
    output logic           ms_to_ws_valid,
    output logic [103:0]   ms_to_ws_bus,
    input  logic           data_sram_data_ok,
    input  logic [31:0]    data_sram_rdata,
    input  logic           wb_ex,
    output logic [39:0]    ms_fwd_bus
);

    localparam logic [1:0] c_CANCEL_MAX = 2'd3;

    logic           ms_valid_q, ms_valid_d;
    logic [109:0]   es_bus_q, es_bus_d;
    logic           data_buf_valid_q, data_buf_valid_d;
    logic [31:0]    data_buf_q, data_buf_d;
    logic [1:0]     cancel_cnt_q, cancel_cnt_d;

    logic [33:0]    w_csr_data;
    logic           w_mem_req;
    logic           w_ld_b, w_ld_h, w_ld_w, w_ld_bu, w_ld_hu;
    logic           w_gr_we;
    logic [4:0]     w_dest;
    logic [31:0]    w_alu_result;
    logic [31:0]    w_pc;
    logic           w_is_load;
    logic           w_ready_go;
    logic           w_leave;
    logic           w_buf_capture;
    logic           w_cancel_inc;
    logic           w_cancel_dec;
    logic [31:0]    w_load_src;
    logic [7:0]     w_byte;
    logic [15:0]    w_half;
    logic [31:0]    w_load_ext;
    logic [31:0]    w_final_result;

    assign w_csr_data   = es_bus_q[109:76];
    assign w_mem_req    = es_bus_q[75];
    assign w_ld_b       = es_bus_q[74];
    assign w_ld_h       = es_bus_q[73];
    assign w_ld_w       = es_bus_q[72];
    assign w_ld_bu      = es_bus_q[71];
    assign w_ld_hu      = es_bus_q[70];
    assign w_gr_we      = es_bus_q[69];
    assign w_dest       = es_bus_q[68:64];
    assign w_alu_result = es_bus_q[63:32];
    assign w_pc         = es_bus_q[31:0];
    assign w_is_load    = |es_bus_q[74:70];

    // A response arriving while cancel_cnt is nonzero belongs to a flushed load.
    assign w_ready_go     = !w_mem_req || data_buf_valid_q ||
                            (data_sram_data_ok && (cancel_cnt_q == 2'd0));
    assign ms_allowin     = !ms_valid_q || (w_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && w_ready_go && !wb_ex;
    assign w_leave        = ms_to_ws_valid && ws_allowin;

    assign w_buf_capture  = data_sram_data_ok && (cancel_cnt_q == 2'd0) &&
                            ms_valid_q && w_mem_req && !data_buf_valid_q && !ws_allowin;
    assign w_cancel_inc   = wb_ex && ms_valid_q && w_mem_req && !w_ready_go;
    assign w_cancel_dec   = data_sram_data_ok && (cancel_cnt_q != 2'd0);

    assign w_load_src = data_buf_valid_q ? data_buf_q : data_sram_rdata;

    always_comb begin
        w_byte = w_load_src[7:0];
        case (w_alu_result[1:0])
            2'b00:   w_byte = w_load_src[7:0];
            2'b01:   w_byte = w_load_src[15:8];
            2'b10:   w_byte = w_load_src[23:16];
            default: w_byte = w_load_src[31:24];
        endcase
        w_half = w_alu_result[1] ? w_load_src[31:16] : w_load_src[15:0];

        w_load_ext = w_load_src;
        if (w_ld_b)       w_load_ext = {{24{w_byte[7]}}, w_byte};
        else if (w_ld_bu) w_load_ext = {24'd0, w_byte};
        else if (w_ld_h)  w_load_ext = {{16{w_half[15]}}, w_half};
        else if (w_ld_hu) w_load_ext = {16'd0, w_half};
        else if (w_ld_w)  w_load_ext = w_load_src;

        w_final_result = w_is_load ? w_load_ext : w_alu_result;
    end

    assign ms_to_ws_bus = {w_csr_data, w_gr_we, w_dest, w_final_result, w_pc};
    assign ms_fwd_bus   = {ms_valid_q,
                           ms_valid_q && w_is_load && !w_ready_go,
                           ms_valid_q && w_gr_we,
                           w_dest,
                           w_final_result};

    always_comb begin
        ms_valid_d = ms_valid_q;
        if (wb_ex)
            ms_valid_d = 1'b0;
        else if (ms_allowin)
            ms_valid_d = es_to_ms_valid;

        es_bus_d = es_bus_q;
        if (es_to_ms_valid && ms_allowin)
            es_bus_d = es_to_ms_bus;

        data_buf_valid_d = data_buf_valid_q;
        data_buf_d       = data_buf_q;
        if (wb_ex || w_leave) begin
            data_buf_valid_d = 1'b0;
        end else if (w_buf_capture) begin
            data_buf_valid_d = 1'b1;
            data_buf_d       = data_sram_rdata;
        end

        cancel_cnt_d = cancel_cnt_q;
        if (w_cancel_inc && !w_cancel_dec && (cancel_cnt_q != c_CANCEL_MAX))
            cancel_cnt_d = cancel_cnt_q + 2'd1;
        else if (w_cancel_dec && !w_cancel_inc)
            cancel_cnt_d = cancel_cnt_q - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid_q       <= 1'b0;
            data_buf_valid_q <= 1'b0;
            cancel_cnt_q     <= 2'd0;
        end else begin
            ms_valid_q       <= ms_valid_d;
            data_buf_valid_q <= data_buf_valid_d;
            cancel_cnt_q     <= cancel_cnt_d;
        end
    end

    // Payload registers are qualified by ms_valid / data_buf_valid, so no reset.
    always_ff @(posedge clk) begin
        es_bus_q   <= es_bus_d;
        data_buf_q <= data_buf_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Directed, table-driven self-checking bench for mem_stage.
// Revision : 1.0
// ============================================================================
module tb_mem_stage;

    localparam logic [4:0] c_OP_NONE = 5'b00000;
    localparam logic [4:0] c_OP_LD_B  = 5'b10000;
    localparam logic [4:0] c_OP_LD_H  = 5'b01000;
    localparam logic [4:0] c_OP_LD_W  = 5'b00100;
    localparam logic [4:0] c_OP_LD_BU = 5'b00010;
    localparam logic [4:0] c_OP_LD_HU = 5'b00001;

    logic           clk = 1'b0;
    logic           resetn;
    logic           ms_allowin;
    logic           es_to_ms_valid;
    logic [109:0]   es_to_ms_bus;
    logic           ws_allowin;
    logic           ms_to_ws_valid;
    logic [103:0]   ms_to_ws_bus;
    logic           data_sram_data_ok;
    logic [31:0]    data_sram_rdata;
    logic           wb_ex;
    logic [39:0]    ms_fwd_bus;

    int checks   = 0;
    int failures = 0;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .wb_ex             (wb_ex),
        .ms_fwd_bus        (ms_fwd_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic        mreq;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [103:0] act, input logic [103:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [109:0] mk(input logic [4:0] op, input logic mreq,
                                        input logic [31:0] alu, input logic [31:0] pc,
                                        input logic [4:0] dest, input logic gwe,
                                        input logic [33:0] csr);
        return {csr, mreq, op, gwe, dest, alu, pc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enter(input logic [4:0] op, input logic [31:0] alu);
        tick();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(op, 1'b1, alu, 32'h0000_8000, 5'd7, 1'b1, 34'h0);
    endtask

    initial begin
        vecs[0]  = '{c_OP_NONE, 1'b0, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678};
        vecs[1]  = '{c_OP_LD_B,  1'b1, 32'h0000_0003, 32'h80FF_0000, 32'hFFFF_FF80};
        vecs[2]  = '{c_OP_LD_BU, 1'b1, 32'h0000_0003, 32'h80FF_0000, 32'h0000_0080};
        vecs[3]  = '{c_OP_LD_B,  1'b1, 32'h0000_0000, 32'h1234_567F, 32'h0000_007F};
        vecs[4]  = '{c_OP_LD_B,  1'b1, 32'h0000_0001, 32'h0000_A500, 32'hFFFF_FFA5};
        vecs[5]  = '{c_OP_LD_BU, 1'b1, 32'h0000_0002, 32'h00C3_0000, 32'h0000_00C3};
        vecs[6]  = '{c_OP_LD_H,  1'b1, 32'h0000_0000, 32'h0000_8001, 32'hFFFF_8001};
        vecs[7]  = '{c_OP_LD_HU, 1'b1, 32'h0000_0002, 32'h9ABC_0000, 32'h0000_9ABC};
        vecs[8]  = '{c_OP_LD_H,  1'b1, 32'h0000_0002, 32'h7FFF_0000, 32'h0000_7FFF};
        vecs[9]  = '{c_OP_LD_W,  1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[10] = '{c_OP_NONE, 1'b1, 32'h0000_1000, 32'h5555_5555, 32'h0000_1000};

        resetn            = 1'b0;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        ws_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        wb_ex             = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("reset_to_ws_valid", {103'd0, ms_to_ws_valid}, 104'd0);
        chk("reset_allowin",     {103'd0, ms_allowin},     104'd1);
        chk("reset_fwd_valid",   {103'd0, ms_fwd_bus[39]}, 104'd0);
        tick();
        resetn = 1'b1;

        // Single-cycle instructions and loads answered in their first MEM cycle.
        for (int i = 0; i < 11; i++) begin
            logic [4:0]  dest;
            logic        gwe;
            logic [31:0] pc;
            logic [33:0] csr;
            dest = 5'(i + 1);
            gwe  = i[0];
            pc   = 32'h0000_1000 + 32'(i * 4);
            csr  = 34'h2_0000_0000 | 34'(i);
            tick();
            es_to_ms_valid = 1'b1;
            es_to_ms_bus   = mk(vecs[i].op, vecs[i].mreq, vecs[i].alu, pc, dest, gwe, csr);
            tick();
            es_to_ms_valid    = 1'b0;
            data_sram_data_ok = vecs[i].mreq;
            data_sram_rdata   = vecs[i].rdata;
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), {103'd0, ms_to_ws_valid}, 104'd1);
            chk($sformatf("vec%0d_bus", i), ms_to_ws_bus, {csr, gwe, dest, vecs[i].exp, pc});
            chk($sformatf("vec%0d_fwd", i), {64'd0, ms_fwd_bus},
                {64'd0, 1'b1, 1'b0, gwe, dest, vecs[i].exp});
            tick();
            data_sram_data_ok = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_drained", i), {102'd0, ms_to_ws_valid, ms_allowin}, 104'd1);
        end

        // ld_h with a response three cycles late.
        enter(c_OP_LD_H, 32'h0000_0000);
        for (int k = 0; k < 3; k++) begin
            tick();
            es_to_ms_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("ldh_wait%0d", k), {101'd0, ms_to_ws_valid, ms_allowin, ms_fwd_bus[38]},
                104'd1);
        end
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_8001;
        @(negedge clk);
        chk("ldh_done_valid",  {103'd0, ms_to_ws_valid}, 104'd1);
        chk("ldh_done_result", {72'd0, ms_to_ws_bus[63:32]}, {72'd0, 32'hFFFF_8001});
        tick();
        data_sram_data_ok = 1'b0;

        // ld_w response arrives while WB stalls, then same-cycle exit and entry.
        ws_allowin = 1'b0;
        enter(c_OP_LD_W, 32'h0000_0100);
        tick();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("buf_ok_cycle", {102'd0, ms_to_ws_valid, ms_allowin}, 104'd2);
        for (int k = 0; k < 2; k++) begin
            tick();
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = 32'h1111_1111;
            @(negedge clk);
            chk($sformatf("buf_hold%0d", k), {70'd0, ms_to_ws_valid, ms_allowin, ms_to_ws_bus[63:32]},
                {70'd0, 1'b1, 1'b0, 32'hDEAD_BEEF});
        end
        enter(c_OP_LD_W, 32'h0000_0104);
        ws_allowin = 1'b1;
        @(negedge clk);
        chk("buf_release", {70'd0, ms_to_ws_valid, ms_allowin, ms_to_ws_bus[63:32]},
            {70'd0, 1'b1, 1'b1, 32'hDEAD_BEEF});
        tick();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        chk("swap_buf_cleared", {101'd0, ms_to_ws_valid, ms_fwd_bus[39], ms_fwd_bus[38]}, 104'd3);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0BAD_F00D;
        @(negedge clk);
        chk("swap_result", {71'd0, ms_to_ws_valid, ms_to_ws_bus[63:32]}, {71'd0, 1'b1, 32'h0BAD_F00D});
        tick();
        data_sram_data_ok = 1'b0;

        // Flush with a load outstanding: the stale response must be dropped.
        enter(c_OP_LD_W, 32'h0000_0200);
        tick();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        chk("flush_pre_blocking", {103'd0, ms_fwd_bus[38]}, 104'd1);
        tick();
        wb_ex = 1'b1;
        @(negedge clk);
        chk("flush_no_valid", {103'd0, ms_to_ws_valid}, 104'd0);
        tick();
        wb_ex = 1'b0;
        @(negedge clk);
        chk("flush_emptied", {102'd0, ms_fwd_bus[39], ms_allowin}, 104'd1);
        enter(c_OP_LD_BU, 32'h0000_0201);
        tick();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hAAAA_AAAA;
        @(negedge clk);
        chk("stale_dropped", {102'd0, ms_to_ws_valid, ms_fwd_bus[38]}, 104'd1);
        tick();
        data_sram_rdata = 32'h0000_3C00;
        @(negedge clk);
        chk("after_stale_result", {71'd0, ms_to_ws_valid, ms_to_ws_bus[63:32]},
            {71'd0, 1'b1, 32'h0000_003C});
        tick();
        data_sram_data_ok = 1'b0;

        // Flushing a non-memory instruction leaves nothing to cancel.
        tick();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(c_OP_NONE, 1'b0, 32'h0000_0077, 32'h0000_9000, 5'd3, 1'b1, 34'h0);
        tick();
        es_to_ms_valid = 1'b0;
        wb_ex          = 1'b1;
        @(negedge clk);
        chk("alu_flush_masked", {103'd0, ms_to_ws_valid}, 104'd0);
        tick();
        wb_ex = 1'b0;
        enter(c_OP_LD_W, 32'h0000_0300);
        tick();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1357_9BDF;
        @(negedge clk);
        chk("no_cancel_result", {71'd0, ms_to_ws_valid, ms_to_ws_bus[63:32]},
            {71'd0, 1'b1, 32'h1357_9BDF});
        tick();
        data_sram_data_ok = 1'b0;

        // Reset while a buffered load waits on WB.
        ws_allowin = 1'b0;
        enter(c_OP_LD_W, 32'h0000_0400);
        tick();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_F00D;
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        @(negedge clk);
        chk("pre_reset_buffered", {71'd0, ms_to_ws_valid, ms_to_ws_bus[63:32]},
            {71'd0, 1'b1, 32'hCAFE_F00D});
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        @(negedge clk);
        chk("midreset_state", {101'd0, ms_to_ws_valid, ms_allowin, ms_fwd_bus[39]}, 104'd2);
        ws_allowin = 1'b1;
        enter(c_OP_LD_HU, 32'h0000_0002);
        tick();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        chk("post_reset_buf_clear", {102'd0, ms_to_ws_valid, ms_fwd_bus[38]}, 104'd1);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBEEF_0000;
        @(negedge clk);
        chk("post_reset_result", {71'd0, ms_to_ws_valid, ms_to_ws_bus[63:32]},
            {71'd0, 1'b1, 32'h0000_BEEF});
        tick();
        data_sram_data_ok = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: MEM_stage

Interface
REQ-001 clk  in  1  — sole clock; all state updates on posedge clk.
REQ-002 resetn  in  1  — synchronous, active-low reset, sampled on posedge clk.
REQ-003 ms_allowin  out  1  — MEM can accept a new instruction this cycle.
REQ-004 es_to_ms_valid  in  1  — EX presents a valid instruction.
REQ-005 es_to_ms_bus  in  110  — {csr_data[33:0], mem_req, load_op[4:0] = {ld_b, ld_h, ld_w, ld_bu, ld_hu}, gr_we, dest[4:0], alu_result[31:0], pc[31:0]}, MSB first.
REQ-006 ws_allowin  in  1  — WB can accept an instruction.
REQ-007 ms_to_ws_valid  out  1  — MEM presents a completed instruction to WB.
REQ-008 ms_to_ws_bus  out  104  — {csr_data[33:0], gr_we, dest[4:0], final_result[31:0], pc[31:0]}, MSB first.
REQ-009 data_sram_data_ok  in  1  — one-cycle pulse: the data-memory response for the oldest outstanding request.
REQ-010 data_sram_rdata  in  32  — response data, valid only while data_ok is high.
REQ-011 wb_ex  in  1  — exception/flush from WB.
REQ-012 ms_fwd_bus  out  40  — {ms_valid, ms_blocking, ms_rf_we, dest[4:0], final_result[31:0]}, consumed by ID for bypass and stall.

Function
REQ-013 Internal state SHALL be:
- ms_valid;
- the latched es_to_ms_bus register (es_bus_r);
- data_buf_valid with data_buf[31:0];
- cancel_cnt[1:0].
REQ-014 Handshake and ready:
- ms_allowin SHALL equal !ms_valid || (ms_ready_go && ws_allowin).
- ms_to_ws_valid SHALL equal ms_valid && ms_ready_go && !wb_ex.
REQ-015 When es_to_ms_valid && ms_allowin, es_bus_r SHALL load es_to_ms_bus; es_bus_r SHALL hold its value otherwise.
REQ-016 ms_valid update, in priority order:
- 0 on reset;
- 0 when wb_ex is high;
- es_to_ms_valid when ms_allowin is high;
- otherwise hold.
REQ-017 ms_ready_go SHALL equal !mem_req || data_buf_valid || (data_sram_data_ok && cancel_cnt == 0); a non-memory instruction completes in MEM with 1-cycle latency.
REQ-018 data_sram_data_ok buffering:
- Condition: data_ok arrives while cancel_cnt == 0, ms_valid && mem_req, data_buf_valid is low, and ws_allowin is low.
- Action: data_buf SHALL capture data_sram_rdata and data_buf_valid SHALL set.
- data_buf_valid SHALL clear when the instruction leaves MEM (ms_to_ws_valid && ws_allowin) or on wb_ex.
REQ-019 Load data source: the buffered data when data_buf_valid is high, else data_sram_rdata.
REQ-020 Byte and halfword select:
- The byte lane SHALL be selected by alu_result[1:0].
- The halfword SHALL be selected by alu_result[1].
REQ-021 Load extension:
- ld_b sign-extends 8 bits and ld_bu zero-extends 8 bits.
- ld_h sign-extends 16 bits and ld_hu zero-extends 16 bits.
- ld_w passes 32 bits unchanged.
REQ-022 final_result SHALL be the extended load data when any load_op bit is set, else alu_result.
REQ-023 cancel_cnt tracks responses to be dropped after a flush:
- Increment when wb_ex occurs while ms_valid && mem_req && !ms_ready_go, i.e. the response is still outstanding.
- Decrement on each data_ok received while cancel_cnt != 0; that data_ok SHALL be discarded and SHALL NOT complete any instruction.
- If increment and decrement occur in the same cycle, the count SHALL hold.
- Saturate at 3.
REQ-024 ms_blocking SHALL equal ms_valid && (load_op != 0) && !ms_ready_go.
REQ-025 ms_rf_we SHALL equal ms_valid && gr_we.
REQ-026 Same-cycle entry and exit: when one instruction leaves and a new one enters in the same cycle, the new es_bus_r SHALL be visible the next cycle with data_buf_valid cleared.
REQ-027 csr_data, gr_we, dest and pc SHALL pass unmodified from es_bus_r to ms_to_ws_bus.

Reset
REQ-028 While resetn is low, the following SHALL be 0 at the next edge: ms_valid, data_buf_valid, cancel_cnt.
REQ-029 Out of reset, the outputs SHALL be: ms_to_ws_valid 0, ms_allowin 1, ms_fwd_bus[39] 0.
REQ-030 es_bus_r SHALL NOT require reset; its contents SHALL be masked by ms_valid everywhere.

Verification
REQ-031 ALU op: alu_result=0x1234_5678, mem_req=0, ws_allowin=1 -> next cycle ms_to_ws_valid=1, final_result=0x1234_5678.
REQ-032 ld_b at alu_result[1:0]=2'b11, rdata=0x80FF_0000 with data_ok in the first MEM cycle -> final_result=0xFFFF_FF80. The same case with ld_bu -> 0x0000_0080.
REQ-033 ld_h, alu_result[1]=0, data_ok delayed 3 cycles -> during the wait ms_to_ws_valid=0, ms_allowin=0, ms_blocking=1. On data_ok with rdata=0x0000_8001 -> 0xFFFF_8001 passes to WB in that cycle.
REQ-034 ld_w, data_ok with rdata=0xDEAD_BEEF while ws_allowin=0 for 2 cycles -> data_buf_valid=1. When ws_allowin rises -> 0xDEAD_BEEF is delivered, and data_buf_valid=0 the next cycle.
REQ-035 Load outstanding, wb_ex pulses:
- Next cycle: ms_valid=0, cancel_cnt=1.
- A new load enters.
- The first data_ok (stale) is dropped and cancel_cnt returns to 0.
- The second data_ok completes the new load with its own data.
REQ-036 resetn driven low mid-wait, with a load pending and data_buf_valid=1 -> next cycle ms_valid=0, data_buf_valid=0, cancel_cnt=0, ms_allowin=1.
